// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define DIV_FAST_PATH_EN to resolve |dividend| < |divisor| in a single cycle.
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            kill,
   output logic            ex_stall,
   output logic [XLEN-1:0] result,
   output logic            result_valid,
   output logic            busy
);
   localparam int CNT_W = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_q;
   logic [XLEN-1:0]   quo_q, div_q, rem_q, result_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              neg_q, rneg_q, is_rem_q;

   logic              signed_op, go, div0, ovf, fast, special, ge;
   logic [XLEN-1:0]   min_val, a_mag, b_mag, spec_res, quo_d, rem_d, fin_res;
   logic [XLEN:0]     sh, sub;

   assign signed_op = !op[0];
   assign go        = start && !kill;
   assign min_val   = {1'b1, {(XLEN-1){1'b0}}};
   assign a_mag     = (signed_op && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
   assign b_mag     = (signed_op && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;
   assign div0      = rs2_data == '0;
   assign ovf       = signed_op && rs1_data == min_val && rs2_data == '1;
`ifdef DIV_FAST_PATH_EN
   assign fast      = !div0 && a_mag < b_mag;
`else
   assign fast      = 1'b0;
`endif
   assign special   = div0 || ovf || fast;
   assign spec_res  = div0 ? (op[1] ? rs1_data : '1) :
                      ovf  ? (op[1] ? '0 : min_val) :
                             (op[1] ? rs1_data : '0);

   // The working remainder is one bit wider; a borrow out of the subtract means rem < divisor.
   assign sh      = {rem_q, quo_q[XLEN-1]};
   assign sub     = sh - {1'b0, div_q};
   assign ge      = !sub[XLEN];
   assign rem_d   = ge ? sub[XLEN-1:0] : sh[XLEN-1:0];
   assign quo_d   = {quo_q[XLEN-2:0], ge};
   assign fin_res = is_rem_q ? (rneg_q ? -rem_d : rem_d) : (neg_q ? -quo_d : quo_d);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         quo_q    <= '0;
         div_q    <= '0;
         rem_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         is_rem_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (go) begin
               is_rem_q <= op[1];
               neg_q    <= signed_op && (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
               rneg_q   <= signed_op && rs1_data[XLEN-1];
               quo_q    <= a_mag;
               div_q    <= b_mag;
               rem_q    <= '0;
               cnt_q    <= '0;
               if (special) result_q <= spec_res;
               state_q  <= special ? DONE : CALC;
            end
            CALC: if (kill) state_q <= IDLE;
            else begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(XLEN-1)) begin
                  result_q <= fin_res;
                  state_q  <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Stall in IDLE is combinational so the pipeline freezes the cycle the div enters EX.
   assign ex_stall     = !rst && (state_q == IDLE ? go : state_q == CALC);
   assign result_valid = !rst && state_q == DONE && !kill;
   assign busy         = !rst && state_q != IDLE;
   assign result       = result_q;
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 integer divider for the RV32M DIV/DIVU/REM/REMU ops in the EX stage.
- Sits directly upstream of the hazard unit. Its stall output drives the hazard unit's ex_stall input, which freezes the whole pipeline while a division is in flight.
- Its result feeds the EX result mux into EX/MEM.

Parameters:
- XLEN, 32, operand/result width in bits; must be a power of two ≥ 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  EX holds a valid div-class instruction (id_ex_valid && is_div).
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- rs1_data  input  XLEN  dividend, post-forwarding.
- rs2_data  input  XLEN  divisor, post-forwarding.
- kill  input  1  abort in-flight op (trap/interrupt); not a pipeline flush.
- ex_stall  output  1  to hazard unit; hold all stages this cycle.
- result  output  XLEN  quotient or remainder per op.
- result_valid  output  1  result valid this cycle; EX/MEM captures it.
- busy  output  1  FSM not IDLE (debug/perf).

Behaviour:
- Single clock domain. Reset is synchronous and active-high on clk. No async paths.
- While rst=1, the FSM goes to IDLE and ex_stall, result_valid, busy, result are all 0. Reset mid-operation discards the op, with no result_valid.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - ex_stall = start && !kill (combinational, so the pipeline freezes in the same cycle the div enters EX).
  - On start && !kill, latch op, sign info, |rs1|, |rs2|, and clear remainder and count.
  - Go to DONE if a special case applies, else go to CALC.
- CALC:
  - ex_stall=1.
  - One restoring step per cycle: shift {rem,quo} left 1; if rem ≥ divisor, subtract and set quo[0].
  - count increments 0..XLEN-1; go to DONE after the XLEN-th step.
- DONE:
  - ex_stall=0 and result_valid=1; result holds the sign-corrected value.
  - The pipeline advances at the end of this cycle. start is ignored in DONE.
  - Always return to IDLE, so back-to-back divs get a fresh start in IDLE.
- Latency:
  - Normal op: ex_stall high for XLEN+1 cycles (IDLE + XLEN×CALC), result_valid on cycle XLEN+1 after start is first seen.
  - Special case: ex_stall high 1 cycle, result_valid on the next cycle.
- Signed ops (DIV/REM):
  - Operate on magnitudes.
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the dividend's sign.
- Unsigned ops use raw operands.
- Special cases (RISC-V spec, no trap), resolved in IDLE → DONE:
  - Divisor = 0: quotient = all-ones; remainder = rs1_data.
  - Signed overflow (rs1 = 0x8000_0000, rs2 = -1, DIV/REM only): quotient = 0x8000_0000; remainder = 0.
- kill:
  - kill in CALC or DONE: next state IDLE, ex_stall=0 from the next cycle, and no result_valid that cycle or later.
  - kill with start in IDLE: kill wins, no stall.
- result holds its last value outside DONE. It is only meaningful when result_valid=1.
- Width rules:
  - Remainder register is XLEN+1 bits for the compare/subtract.
  - Negation is two's complement modulo 2^XLEN.

Optional Feature:
- Macro: DIV_FAST_PATH_EN.
- Defined:
  - In IDLE, if |dividend| < |divisor| (unsigned compare of magnitudes, divisor ≠ 0), take the special-case path.
  - Quotient = 0, remainder = rs1_data.
  - 1-cycle stall.
- Undefined:
  - Such operands run the full XLEN-step CALC.
  - Same result, normal latency.
- The result value must be identical either way.

Test Plan:
- DIV 100 / 7 → result 14; ex_stall high exactly 33 consecutive cycles; result_valid 1 on cycle 33; then REM of the same operands → 2.
- REM -7 / 2 → 0xFFFF_FFFF (-1); DIV -7 / 2 → 0xFFFF_FFFD (-3); DIVU 0xFFFF_FFF9 / 2 → 0x7FFF_FFFC.
- DIVU 5 / 0 → 0xFFFF_FFFF and REMU 5 / 0 → 5; each stalls 1 cycle.
- DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000, REM → 0; each stalls 1 cycle.
- Two DIVs back-to-back (start held after DONE) → two separate 33-cycle stall windows separated by one ex_stall=0 DONE cycle, both results correct.
- rst at CALC cycle 10 → ex_stall 0, busy 0 next cycle, no result_valid. Repeat with kill → same response, and the next start divides normally.
